// File: rtl/csa_accumulator_pkg.sv
// Shared types and default sizing for the carry-save accumulator.
// Holds the controller state encoding and the default operand/counter widths.
package csa_accumulator_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

endpackage

// File: rtl/csa_stage.sv
// Parametrised 3:2 carry-save compressor: bitwise sum plus majority carry
// shifted up one place, with the carry out of the top bit dropped.
module csa_stage
  import csa_accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] ci,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] ca
);

  logic [WIDTH-1:0] maj;

  assign s   = a ^ b ^ ci;
  assign maj = (a & b) | (a & ci) | (b & ci);
  assign ca  = {maj[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// Group accumulator: operands are folded into a redundant sum/carry pair and
// only resolved with a real carry-propagate add once the group is complete.
//
// state   | meaning
// ACC     | accepting operands, compressing into sum_q/carry_q
// RESOLVE | one cycle: add sum_q + carry_q into the output register
// OUT     | result presented, held until the consumer takes it
module csa_accumulator
  import csa_accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  input  logic             out_ready
);

  state_t state_q, state_d;

  logic [WIDTH-1:0] sum_q, carry_q;
  logic [WIDTH-1:0] sum_nx, carry_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CNT_W-1:0] out_count_q;
  logic             rst_done_q;
  logic             accept;
  logic             out_take;

  assign accept   = in_valid && in_ready;
  assign out_take = (state_q == OUT) && out_ready;

  csa_stage #(.WIDTH(WIDTH)) u_csa (
    .a  (sum_q),
    .b  (carry_q),
    .ci (in_data),
    .s  (sum_nx),
    .ca (carry_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACC;
    end else begin
      case (state_q)
        ACC:     if (accept && in_last) state_d = RESOLVE;
        RESOLVE: state_d = OUT;
        OUT:     if (out_ready) state_d = ACC;
        default: state_d = ACC;
      endcase
    end
  end

  // in_ready stays low until the first clock edge after reset release.
  always_comb begin
    in_ready  = rst_done_q && (state_q == ACC) && !clear;
    out_valid = (state_q == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
    end else if (clear || out_take) begin
      sum_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      sum_q   <= sum_nx;
      carry_q <= carry_nx;
      if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end
  end

  // The only carry-propagate adder; output registers hold through OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_count_q <= '0;
    end else if (!clear && (state_q == RESOLVE)) begin
      out_data_q  <= sum_q + carry_q;
      out_count_q <= cnt_q;
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: a 32-bit/8-bit-counter instance and an
// 8-bit/2-bit-counter instance share one stimulus stream.
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, in_valid, in_last, out_ready;
  logic [31:0] in_data;

  logic        rdy32, ov32;
  logic [31:0] od32;
  logic [7:0]  oc32;
  logic        rdy8, ov8;
  logic [7:0]  od8;
  logic [1:0]  oc8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csa_accumulator #(.WIDTH(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(rdy32),
    .out_valid(ov32), .out_data(od32), .out_count(oc32), .out_ready(out_ready)
  );

  csa_accumulator #(.WIDTH(8), .CNT_W(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data[7:0]), .in_last(in_last), .in_ready(rdy8),
    .out_valid(ov8), .out_data(od8), .out_count(oc8), .out_ready(out_ready)
  );

  typedef struct {
    logic [31:0] d;
    bit          last;
    logic [31:0] e32;
    logic [7:0]  c32;
    logic [7:0]  e8;
    logic [1:0]  c8;
  } vec_t;

  vec_t tab[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit l, input bit c, input bit r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    clear     = c;
    out_ready = r;
    #1;
  endtask

  // Call right after the cycle that presented the last operand.
  task automatic expect_result(input logic [31:0] e32, input logic [7:0] c32,
                               input logic [7:0] e8, input logic [1:0] c8);
    drive(0, 32'h0, 0, 0, 0);
    chk("valid_t1_32", 64'(ov32), 64'd0);
    chk("valid_t1_8", 64'(ov8), 64'd0);
    drive(0, 32'h0, 0, 0, 1);
    chk("valid_t2_32", 64'(ov32), 64'd1);
    chk("data32", 64'(od32), 64'(e32));
    chk("count32", 64'(oc32), 64'(c32));
    chk("valid_t2_8", 64'(ov8), 64'd1);
    chk("data8", 64'(od8), 64'(e8));
    chk("count8", 64'(oc8), 64'(c8));
    drive(0, 32'h0, 0, 0, 0);
    chk("ready_after_hs", 64'(rdy32), 64'd1);
    chk("valid_after_hs", 64'(ov32), 64'd0);
  endtask

  function automatic vec_t mk(input logic [31:0] d, input bit last, input logic [31:0] e32,
                              input logic [7:0] c32, input logic [7:0] e8, input logic [1:0] c8);
    vec_t t;
    t.d = d; t.last = last; t.e32 = e32; t.c32 = c32; t.e8 = e8; t.c8 = c8;
    return t;
  endfunction

  // Reference model state: plain modular sum and an unbounded operand count.
  int          mode;
  logic [31:0] m_sum, r_sum;
  int          m_cnt, r_cnt;

  initial begin
    bit v, l, c, r, acc;
    logic [31:0] d;

    tab[0]  = mk(32'd5, 0, 0, 0, 0, 0);
    tab[1]  = mk(32'd7, 0, 0, 0, 0, 0);
    tab[2]  = mk(32'd9, 1, 32'd21, 8'd3, 8'd21, 2'd3);
    tab[3]  = mk(32'hFF, 0, 0, 0, 0, 0);
    tab[4]  = mk(32'h02, 1, 32'h101, 8'd2, 8'h01, 2'd2);
    tab[5]  = mk(32'd1, 0, 0, 0, 0, 0);
    tab[6]  = mk(32'd1, 0, 0, 0, 0, 0);
    tab[7]  = mk(32'd1, 0, 0, 0, 0, 0);
    tab[8]  = mk(32'd1, 0, 0, 0, 0, 0);
    tab[9]  = mk(32'd1, 1, 32'd5, 8'd5, 8'd5, 2'd3);
    tab[10] = mk(32'hFFFFFFFF, 0, 0, 0, 0, 0);
    tab[11] = mk(32'h3, 1, 32'h2, 8'd2, 8'h02, 2'd2);
    tab[12] = mk(32'h80000001, 1, 32'h80000001, 8'd1, 8'h01, 2'd1);

    rst_n = 1'b0; clear = 0; in_valid = 0; in_last = 0; out_ready = 0; in_data = '0;
    #12;
    chk("rst_ready", 64'(rdy32), 64'd0);
    chk("rst_valid", 64'(ov32), 64'd0);
    chk("rst_data", 64'(od32), 64'd0);
    #10 rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 64'(rdy32), 64'd0);

    foreach (tab[i]) begin
      drive(1, tab[i].d, tab[i].last, 0, 0);
      chk("ready32", 64'(rdy32), 64'd1);
      chk("ready8", 64'(rdy8), 64'd1);
      if (tab[i].last) expect_result(tab[i].e32, tab[i].c32, tab[i].e8, tab[i].c8);
    end

    // Result held while the consumer stalls.
    drive(1, 32'h1234, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'hAAAA, 0, 0, 0);
      chk("stall_valid", 64'(ov32), 64'd1);
      chk("stall_data", 64'(od32), 64'h1234);
      chk("stall_count", 64'(oc32), 64'd1);
      chk("stall_ready", 64'(rdy32), 64'd0);
    end
    drive(0, 32'h0, 0, 0, 1);
    chk("stall_hs_valid", 64'(ov32), 64'd1);
    drive(0, 32'h0, 0, 0, 0);
    chk("stall_after_ready", 64'(rdy32), 64'd1);

    // Abort mid-group, stray in_last/out_ready ignored, then a fresh group.
    drive(1, 32'd3, 0, 0, 0);
    drive(1, 32'd4, 0, 0, 0);
    drive(1, 32'd10, 0, 1, 0);
    chk("clear_ready", 64'(rdy32), 64'd0);
    drive(0, 32'd0, 1, 0, 1);
    chk("clear_no_valid", 64'(ov32), 64'd0);
    chk("clear_ready_back", 64'(rdy32), 64'd1);
    drive(0, 32'd0, 0, 0, 0);
    chk("lone_last_ignored", 64'(ov32), 64'd0);
    drive(1, 32'd1, 0, 0, 0);
    drive(1, 32'd1, 1, 0, 0);
    expect_result(32'd2, 8'd2, 8'd2, 2'd2);

    // Clear beats the output handshake.
    drive(1, 32'd7, 1, 0, 0);
    drive(0, 32'd0, 0, 0, 0);
    drive(0, 32'd0, 0, 1, 1);
    chk("clear_in_out_valid", 64'(ov32), 64'd1);
    drive(0, 32'd0, 0, 0, 0);
    chk("clear_in_out_after", 64'(ov32), 64'd0);
    chk("clear_in_out_ready", 64'(rdy32), 64'd1);

    // Asynchronous reset mid-group.
    drive(1, 32'd3, 0, 0, 0);
    drive(1, 32'd3, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grp_ready", 64'(rdy32), 64'd0);
    chk("arst_grp_data", 64'(od32), 64'd0);
    chk("arst_grp_count", 64'(oc32), 64'd0);
    drive(0, 32'd0, 0, 0, 0);
    #2 rst_n = 1'b1;
    drive(1, 32'd6, 1, 0, 0);
    chk("arst_grp_ready_back", 64'(rdy32), 64'd1);
    expect_result(32'd6, 8'd1, 8'd6, 2'd1);

    // Asynchronous reset while presenting a result.
    drive(1, 32'd9, 1, 0, 0);
    drive(0, 32'd0, 0, 0, 0);
    drive(0, 32'd0, 0, 0, 0);
    chk("arst_out_pre_valid", 64'(ov32), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(ov32), 64'd0);
    chk("arst_out_data", 64'(od32), 64'd0);
    chk("arst_out_count", 64'(oc32), 64'd0);
    chk("arst_out_data8", 64'(od8), 64'd0);
    drive(0, 32'd0, 0, 0, 0);
    #2 rst_n = 1'b1;
    drive(1, 32'd6, 1, 0, 0);
    expect_result(32'd6, 8'd1, 8'd6, 2'd1);

    // Randomised traffic against the reference model.
    mode = 0; m_sum = '0; m_cnt = 0; r_sum = '0; r_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      d = $urandom;
      l = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 63) == 0);
      r = ($urandom_range(0, 2) != 0);
      drive(v, d, l, c, r);
      chk("rnd_ready32", 64'(rdy32), 64'(mode == 0 && !c));
      chk("rnd_ready8", 64'(rdy8), 64'(mode == 0 && !c));
      chk("rnd_valid32", 64'(ov32), 64'(mode == 2));
      chk("rnd_valid8", 64'(ov8), 64'(mode == 2));
      if (mode == 2) begin
        chk("rnd_data32", 64'(od32), 64'(r_sum));
        chk("rnd_data8", 64'(od8), 64'(r_sum[7:0]));
        chk("rnd_count32", 64'(oc32), 64'((r_cnt > 255) ? 255 : r_cnt));
        chk("rnd_count8", 64'(oc8), 64'((r_cnt > 3) ? 3 : r_cnt));
      end
      acc = v && (mode == 0) && !c;
      if (c) begin
        mode = 0; m_sum = '0; m_cnt = 0;
      end else if (mode == 0) begin
        if (acc) begin
          m_sum = m_sum + d;
          m_cnt++;
          if (l) begin
            r_sum = m_sum; r_cnt = m_cnt; mode = 1;
          end
        end
      end else if (mode == 1) begin
        mode = 2;
      end else if (r) begin
        mode = 0; m_sum = '0; m_cnt = 0;
      end
    end

    drive(0, 32'd0, 0, 1, 0);
    drive(0, 32'd0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
